// File: rtl/io_block_cfg_loader.sv
// io_block_cfg_loader
// Loads a config bitstream word by word into a shadow register. It then scans
// the shadow image for wires that two or more external inputs would drive at
// once. A clean image is committed to the gate control vector c in one step.
// A rejected image sets cfg_err and leaves c untouched.
// Optional feature: define IO_CFG_READBACK_EN to add the rb_req/rb_data/rb_valid
// readback of the active c.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for cfg_start (or rb_req with readback)
// LOAD     | accepting NWORDS words into the shadow register
// CHECK    | scanning one wire per cycle for input drive conflicts
// COMMIT   | copying the clean shadow image to c
// READBACK | streaming the active c out as words (readback builds only)

module io_block_cfg_loader #(
  parameter  int WS     = 6,
  parameter  int WD     = 3,
  parameter  int WG     = 3,
  parameter  int EXTIN  = 3,
  parameter  int EXTOUT = 3,
  parameter  int WORD   = 8,
  localparam int NW     = WS + WD + WG,
  localparam int CW     = (EXTIN + EXTOUT) * NW,
  localparam int NWORDS = (CW + WORD - 1) / WORD
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cfg_start,
  input  logic [WORD-1:0] cfg_data,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  output logic [CW-1:0]   c,
  output logic            cfg_busy,
  output logic            cfg_done,
  output logic            cfg_err
`ifdef IO_CFG_READBACK_EN
  ,
  input  logic            rb_req,
  output logic [WORD-1:0] rb_data,
  output logic            rb_valid
`endif
);

  localparam int WCW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int SIW = (NW > 1) ? $clog2(NW) : 1;
  localparam logic [WCW-1:0] LAST_WORD = WCW'(NWORDS - 1);
  localparam logic [SIW-1:0] LAST_WIRE = SIW'(NW - 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    COMMIT
`ifdef IO_CFG_READBACK_EN
    ,
    READBACK
`endif
  } state_t;

  state_t                   state;
  logic [WORD-1:0]          shadow_words [NWORDS];
  logic [NWORDS*WORD-1:0]   shadow_flat;
  logic [WCW-1:0]           wcnt;
  logic [SIW-1:0]           scan_idx;
  logic                     err_flag;
  logic [NW-1:0]            conflict_vec;
  logic                     scan_err;

  // Flatten the shadow words; padding bits of the last word fall above CW-1.
  for (genvar gk = 0; gk < NWORDS; gk++) begin : g_flat
    assign shadow_flat[gk*WORD +: WORD] = shadow_words[gk];
  end

  // Per-wire conflict: more than one external input closed onto the same wire.
  for (genvar gj = 0; gj < NW; gj++) begin : g_wire
    logic [EXTIN-1:0] col;
    for (genvar gi = 0; gi < EXTIN; gi++) begin : g_in
      assign col[gi] = shadow_flat[gi*NW + gj];
    end
    assign conflict_vec[gj] = ($countones(col) > 1);
  end

  // Error state including the wire under scan this cycle.
  assign scan_err = err_flag | conflict_vec[scan_idx];

`ifdef IO_CFG_READBACK_EN
  logic [WCW-1:0]         rb_cnt;
  logic [NWORDS*WORD-1:0] c_pad;
  logic [WORD-1:0]        c_words [NWORDS];

  // Zero-extend c to a whole number of words for streaming.
  always_comb begin
    c_pad         = '0;
    c_pad[CW-1:0] = c;
  end

  for (genvar gr = 0; gr < NWORDS; gr++) begin : g_rb
    assign c_words[gr] = c_pad[gr*WORD +: WORD];
  end
`endif

  // Sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      for (int k = 0; k < NWORDS; k++) shadow_words[k] <= '0;
      wcnt      <= '0;
      scan_idx  <= '0;
      err_flag  <= 1'b0;
      c         <= '0;
      cfg_ready <= 1'b0;
      cfg_busy  <= 1'b0;
      cfg_done  <= 1'b0;
      cfg_err   <= 1'b0;
`ifdef IO_CFG_READBACK_EN
      rb_cnt    <= '0;
      rb_data   <= '0;
      rb_valid  <= 1'b0;
`endif
    end else begin
      cfg_done <= 1'b0;
`ifdef IO_CFG_READBACK_EN
      rb_valid <= 1'b0;
`endif
      unique case (state)
        IDLE: begin
          if (cfg_start) begin
            for (int k = 0; k < NWORDS; k++) shadow_words[k] <= '0;
            cfg_err   <= 1'b0;
            wcnt      <= '0;
            cfg_ready <= 1'b1;
            cfg_busy  <= 1'b1;
            state     <= LOAD;
          end
`ifdef IO_CFG_READBACK_EN
          else if (rb_req) begin
            rb_cnt   <= '0;
            cfg_busy <= 1'b1;
            state    <= READBACK;
          end
`endif
        end

        LOAD: begin
          // A restart wins over a word presented in the same cycle.
          if (cfg_start) begin
            for (int k = 0; k < NWORDS; k++) shadow_words[k] <= '0;
            wcnt <= '0;
          end else if (cfg_valid && cfg_ready) begin
            shadow_words[wcnt] <= cfg_data;
            if (wcnt == LAST_WORD) begin
              cfg_ready <= 1'b0;
              scan_idx  <= '0;
              err_flag  <= 1'b0;
              state     <= CHECK;
            end else begin
              wcnt <= wcnt + 1'b1;
            end
          end
        end

        CHECK: begin
          err_flag <= scan_err;
          if (scan_idx == LAST_WIRE) begin
            if (scan_err) begin
              cfg_err  <= 1'b1;
              cfg_busy <= 1'b0;
              state    <= IDLE;
            end else begin
              state <= COMMIT;
            end
          end else begin
            scan_idx <= scan_idx + 1'b1;
          end
        end

        COMMIT: begin
          c        <= shadow_flat[CW-1:0];
          cfg_done <= 1'b1;
          cfg_busy <= 1'b0;
          state    <= IDLE;
        end

`ifdef IO_CFG_READBACK_EN
        READBACK: begin
          rb_valid <= 1'b1;
          rb_data  <= c_words[rb_cnt];
          if (rb_cnt == LAST_WORD) begin
            cfg_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            rb_cnt <= rb_cnt + 1'b1;
          end
        end
`endif

        default: begin
          cfg_ready <= 1'b0;
          cfg_busy  <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_io_block_cfg_loader.sv
// Scoreboard bench for io_block_cfg_loader: the driver pushes the expected
// outcome of each load, and a negedge monitor pops it on cfg_done / cfg_err.

module tb_io_block_cfg_loader;

  localparam int WS = 6, WD = 3, WG = 3, EXTIN = 3, EXTOUT = 3, WORD = 8;
  localparam int NW     = WS + WD + WG;
  localparam int CW     = (EXTIN + EXTOUT) * NW;
  localparam int NWORDS = (CW + WORD - 1) / WORD;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cfg_start = 1'b0;
  logic [WORD-1:0] cfg_data = '0;
  logic            cfg_valid = 1'b0;
  logic            cfg_ready;
  logic [CW-1:0]   c;
  logic            cfg_busy;
  logic            cfg_done;
  logic            cfg_err;
`ifdef IO_CFG_READBACK_EN
  logic            rb_req = 1'b0;
  logic [WORD-1:0] rb_data;
  logic            rb_valid;
`endif

  io_block_cfg_loader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_start (cfg_start),
    .cfg_data  (cfg_data),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .c         (c),
    .cfg_busy  (cfg_busy),
    .cfg_done  (cfg_done),
    .cfg_err   (cfg_err)
`ifdef IO_CFG_READBACK_EN
    ,
    .rb_req    (rb_req),
    .rb_data   (rb_data),
    .rb_valid  (rb_valid)
`endif
  );

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_seen = 1'b0;
  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst_n;
  end

  int total = 0;
  int bad   = 0;

  typedef struct {
    bit            is_err;
    logic [CW-1:0] c_exp;
    int            at_cyc;
  } exp_t;

  exp_t          sb[$];
  logic [CW-1:0] c_model = '0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: assemble the image from words, then apply the drive rule.
  function automatic exp_t model(input logic [WORD-1:0] w[NWORDS]);
    logic [NWORDS*WORD-1:0] flat;
    exp_t e;
    int   n;
    for (int k = 0; k < NWORDS; k++) flat[k*WORD +: WORD] = w[k];
    e.c_exp  = flat[CW-1:0];
    e.is_err = 1'b0;
    e.at_cyc = 0;
    for (int j = 0; j < NW; j++) begin
      n = 0;
      for (int i = 0; i < EXTIN; i++) if (e.c_exp[i*NW + j]) n++;
      if (n > 1) e.is_err = 1'b1;
    end
    return e;
  endfunction

  // Monitor: pop on every completion event, and watch c between commits.
  initial begin : monitor
    exp_t e;
    logic err_q;
    logic got_err;
    err_q = 1'b0;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (!rst_seen) begin
        sb.delete();
        c_model = '0;
        err_q   = 1'b0;
      end else begin
        got_err = cfg_err && !err_q;
        if (cfg_done || got_err) begin
          if (sb.size() == 0) begin
            chk("unexpected_event", {cfg_done, got_err}, 2'b00);
          end else begin
            e = sb.pop_front();
            chk("event_is_err", got_err, e.is_err);
            chk("event_cycle", cyc, e.at_cyc);
            if (cfg_done) begin
              chk("done_c", c, e.c_exp);
              chk("done_with_err", cfg_err, 1'b0);
              c_model = e.c_exp;
            end
          end
        end
        err_q = cfg_err;
      end
      chk("c_stable", c, c_model);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_pulse();
    cfg_start = 1'b1;
    tick();
    cfg_start = 1'b0;
  endtask

  task automatic send_word(input logic [WORD-1:0] w, output int hs);
    int n;
    n = 0;
    cfg_data  = w;
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 20) begin
      tick();
      n++;
    end
    chk("ready_wait", (n < 20), 1'b1);
    tick();
    hs        = cyc;
    cfg_valid = 1'b0;
    cfg_data  = WORD'($urandom);
  endtask

  task automatic load(input logic [WORD-1:0] w[NWORDS], input bit do_start,
                      input int gap_min, input int gap_max, input bit check_ready,
                      input bit poke_check);
    int   hs;
    int   g;
    exp_t e;
    hs = 0;
    if (do_start) start_pulse();
    for (int k = 0; k < NWORDS; k++) begin
      send_word(w[k], hs);
      if (k < NWORDS - 1) begin
        g = $urandom_range(gap_max, gap_min);
        repeat (g) begin
          if (check_ready) chk("ready_in_load", cfg_ready, 1'b1);
          tick();
        end
      end
    end
    chk("ready_drop", cfg_ready, 1'b0);
    e = model(w);
    e.at_cyc = hs + (e.is_err ? NW : NW + 1);
    sb.push_back(e);
    if (poke_check) begin
      tick();
      tick();
      cfg_start = 1'b1;
      tick();
      cfg_start = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    chk("drain_pending", sb.size(), 0);
    tick();
    chk("idle_busy", cfg_busy, 1'b0);
  endtask

  task automatic gen_image(input bit clean, output logic [WORD-1:0] w[NWORDS]);
    logic [NWORDS*WORD-1:0] flat;
    int p;
    for (int k = 0; k < NWORDS; k++) flat[k*WORD +: WORD] = WORD'($urandom);
    if (clean) begin
      for (int j = 0; j < NW; j++) begin
        p = $urandom_range(EXTIN, 0);
        for (int i = 0; i < EXTIN; i++) flat[i*NW + j] = (i == p);
      end
    end
    for (int k = 0; k < NWORDS; k++) w[k] = flat[k*WORD +: WORD];
  endtask

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : driver
    logic [WORD-1:0] img [NWORDS];
    logic [WORD-1:0] junk;
    int              hs;
`ifdef IO_CFG_READBACK_EN
    int              rb_n;
`endif

    // Reset values, then IDLE must ignore cfg_valid.
    rst_n = 1'b0;
    tick();
    tick();
    chk("rst_c", c, '0);
    chk("rst_ready", cfg_ready, 1'b0);
    chk("rst_busy", cfg_busy, 1'b0);
    chk("rst_done", cfg_done, 1'b0);
    chk("rst_err", cfg_err, 1'b0);
`ifdef IO_CFG_READBACK_EN
    chk("rst_rb_valid", rb_valid, 1'b0);
    chk("rst_rb_data", rb_data, '0);
`endif
    rst_n     = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hA5;
    repeat (5) begin
      tick();
      chk("idle_ready", cfg_ready, 1'b0);
      chk("idle_busy_valid", cfg_busy, 1'b0);
      chk("idle_c", c, '0);
    end
    cfg_valid = 1'b0;

    // Single gate: input 0 on single 0.
    for (int k = 0; k < NWORDS; k++) img[k] = '0;
    img[0] = 8'h01;
    load(img, 1'b1, 0, 0, 1'b0, 1'b0);
    chk("busy_in_check", cfg_busy, 1'b1);
    drain();
    chk("s2_c", c, 72'h1);
    chk("s2_err", cfg_err, 1'b0);

    // Inputs 0 and 1 both on single 0: rejected, c keeps 72'h1.
    img[1] = 8'h10;
    load(img, 1'b1, 0, 0, 1'b0, 1'b0);
    drain();
    chk("s3_err", cfg_err, 1'b1);
    chk("s3_c", c, 72'h1);

    // Backpressure: 3 idle cycles between words.
    img[0] = 8'h01;
    img[1] = 8'h00;
    load(img, 1'b1, 3, 3, 1'b1, 1'b0);
    drain();
    chk("s4_c", c, 72'h1);
    chk("s4_err", cfg_err, 1'b0);

    // Restart after 4 words of FF; the restart cycle's word is discarded too.
    start_pulse();
    for (int k = 0; k < 4; k++) send_word(8'hFF, hs);
    cfg_start = 1'b1;
    cfg_valid = 1'b1;
    cfg_data  = 8'hFF;
    tick();
    cfg_start = 1'b0;
    cfg_valid = 1'b0;
    chk("restart_ready", cfg_ready, 1'b1);
    load(img, 1'b0, 0, 0, 1'b0, 1'b0);
    drain();
    chk("s5_c", c, 72'h1);
    chk("s5_err", cfg_err, 1'b0);

`ifdef IO_CFG_READBACK_EN
    // Readback of the active c = 72'h1.
    rb_req = 1'b1;
    tick();
    rb_req = 1'b0;
    chk("rb_busy", cfg_busy, 1'b1);
    rb_n = 0;
    repeat (15) begin
      tick();
      if (rb_valid) begin
        if (rb_n < NWORDS) chk("rb_word", rb_data, (rb_n == 0) ? 8'h01 : 8'h00);
        rb_n++;
      end
    end
    chk("rb_count", rb_n, NWORDS);
`endif

    // Reset in the middle of CHECK after a commit of 72'h1.
    img[0] = 8'h02;
    load(img, 1'b1, 0, 0, 1'b0, 1'b0);
    tick();
    tick();
    tick();
    chk("pre_rst_busy", cfg_busy, 1'b1);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("midrst_c", c, '0);
    chk("midrst_busy", cfg_busy, 1'b0);
    chk("midrst_ready", cfg_ready, 1'b0);
    chk("midrst_done", cfg_done, 1'b0);
    repeat (20) tick();
    chk("midrst_c_later", c, '0);

    // Randomized loads: clean and conflicting images, gaps, restarts, start in CHECK.
    for (int it = 0; it < 24; it++) begin
      if ($urandom_range(3, 0) == 0) begin
        start_pulse();
        repeat ($urandom_range(NWORDS - 1, 0)) begin
          junk = WORD'($urandom);
          send_word(junk, hs);
        end
        cfg_start = 1'b1;
        cfg_valid = 1'b1;
        cfg_data  = WORD'($urandom);
        tick();
        cfg_start = 1'b0;
        cfg_valid = 1'b0;
        gen_image(($urandom_range(1, 0) == 1), img);
        load(img, 1'b0, 0, 2, 1'b1, 1'b0);
      end else begin
        gen_image(($urandom_range(1, 0) == 1), img);
        load(img, 1'b1, 0, 2, 1'b1, ($urandom_range(2, 0) == 0));
      end
      drain();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
